// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory/write-back stage
package mem_pkg;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_REG_AW = 5;
  localparam logic [MEM_REG_AW-1:0] ZERO_REG = '0;
  typedef enum logic {MEM_IDLE, MEM_ACCESS} mem_state_e;
endpackage

// File: rtl/mem_stage.sv
// mem_stage: memory access + write-back stage; execute bundle in, dmem req/ack, rf write port out (optional MEM_MISALIGN_CHK_EN drops misaligned accesses)
module mem_stage #(
  parameter int DATA_W = mem_pkg::MEM_DATA_W,
  parameter int REG_AW = mem_pkg::MEM_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              reg_we_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              misalign_o
);
  import mem_pkg::*;
  mem_state_e state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, sdata_q, sdata_d, rf_wdata_q, rf_wdata_d;
  logic [REG_AW-1:0] cap_waddr_q, cap_waddr_d, rf_waddr_q, rf_waddr_d;
  logic store_q, store_d, cap_we_q, cap_we_d, rf_we_q, rf_we_d, mis_q, mis_d;
  logic mem_op, bad;
  assign mem_op = mem_rd_i | mem_wr_i;
`ifdef MEM_MISALIGN_CHK_EN
  assign bad = alu_data_i[1:0] != 2'b00;
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    sdata_d = sdata_q;
    store_d = store_q;
    cap_we_d = cap_we_q;
    cap_waddr_d = cap_waddr_q;
    rf_we_d = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    mis_d = 1'b0;
    if (state_q == MEM_IDLE) begin
      if (valid_i && mem_op && bad) mis_d = 1'b1;
      else if (valid_i && mem_op) begin
        state_d = MEM_ACCESS;
        addr_d = alu_data_i & ~DATA_W'(3);
        sdata_d = wdata_i;
        store_d = mem_wr_i;
        cap_we_d = reg_we_i;
        cap_waddr_d = waddr_i;
      end else if (valid_i) begin
        rf_we_d = reg_we_i;
        rf_waddr_d = waddr_i;
        rf_wdata_d = alu_data_i;
      end
    end else if (dmem_ack) begin
      state_d = MEM_IDLE;
      if (!store_q) begin
        rf_we_d = cap_we_q;
        rf_waddr_d = cap_waddr_q;
        rf_wdata_d = dmem_rdata;
      end
    end
    // r0 is hardwired zero, so it is never a write (or forwarding) target
    rf_we_d = rf_we_d && (rf_waddr_d != REG_AW'(ZERO_REG));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      addr_q <= '0;
      sdata_q <= '0;
      store_q <= 1'b0;
      cap_we_q <= 1'b0;
      cap_waddr_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      sdata_q <= sdata_d;
      store_q <= store_d;
      cap_we_q <= cap_we_d;
      cap_waddr_q <= cap_waddr_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mis_q <= mis_d;
    end
  end
  assign stall_o = state_q == MEM_ACCESS;
  assign dmem_req = state_q == MEM_ACCESS;
  assign dmem_we = store_q;
  assign dmem_addr = addr_q;
  assign dmem_wdata = sdata_q;
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign misalign_o = mis_q;
endmodule
